// File: rtl/channel_acc_ctrl_pkg.sv
// Shared constants and state encoding for the
// partial-sum accumulation controller.
package channel_acc_ctrl_pkg;

  localparam int ACC_LATENCY_DEF = 6;
  localparam int ADDR_WIDTH_DEF  = 10;
  localparam int TILE_WIDTH_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/channel_acc_ctrl_tag.sv
// Valid+tag delay line matching the adder pipeline latency.
// Invalid slots carry a zero tag so write outputs idle at 0.
module acc_tag_pipe #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] tag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_tag,
  output logic             empty
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] tag [DEPTH];

  // Shift every beat one stage toward the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else begin
      vld    <= {vld[DEPTH-2:0], push};
      tag[0] <= push ? tag_in : '0;
      for (int i = 1; i < DEPTH; i++) tag[i] <= tag[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_tag   = tag[DEPTH-1];
  // Nothing in flight behind the beat now retiring,
  // so the line is clear from the next cycle on.
  assign empty     = ~|vld[DEPTH-2:0];

endmodule

// File: rtl/channel_acc_ctrl.sv
// Sequencer for input-channel partial-sum accumulation:
// read/write strobes, first-pass select, final flag.
module channel_acc_ctrl
  import channel_acc_ctrl_pkg::*;
#(
  parameter int ACC_LATENCY = ACC_LATENCY_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TILE_WIDTH  = TILE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_WIDTH-1:0] cfg_tiles,
  input  logic [ADDR_WIDTH:0]   cfg_pixels,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  psum_rd_en,
  output logic [ADDR_WIDTH-1:0] psum_rd_addr,
  output logic                  acc_first,
  output logic                  psum_wr_en,
  output logic [ADDR_WIDTH-1:0] psum_wr_addr,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  done
);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] pixel;
  logic [TILE_WIDTH-1:0] tile;
  logic [TILE_WIDTH-1:0] tiles_q;
  logic [ADDR_WIDTH:0]   pixels_q;
  logic                  hs, pix_end, tile_end;
  logic                  short_grp, cfg_zero;
  logic                  pipe_empty, wr_vld;
  logic [ADDR_WIDTH:0]   wr_tag;

  assign hs        = in_valid & in_ready;
  assign pix_end   = {1'b0, pixel} ==
                     pixels_q - (ADDR_WIDTH+1)'(1);
  assign tile_end  = tile == tiles_q - TILE_WIDTH'(1);
  assign short_grp = pixels_q <=
                     (ADDR_WIDTH+1)'(ACC_LATENCY);
  assign cfg_zero  = (cfg_tiles == '0) ||
                     (cfg_pixels == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start) state_nx = cfg_zero ? S_DONE : S_RUN;
      S_RUN:
        if (hs && pix_end) begin
          if (tile_end)       state_nx = S_DRAIN;
          else if (short_grp) state_nx = S_HOLD;
        end
      S_HOLD:
        if (pipe_empty) state_nx = S_RUN;
      S_DRAIN:
        if (pipe_empty) state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      S_IDLE:  busy     = 1'b0;
      S_RUN:   in_ready = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  // Config latch and pixel/tile walk
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel    <= '0;
      tile     <= '0;
      tiles_q  <= '0;
      pixels_q <= '0;
    end else if (state == S_IDLE && start) begin
      pixel    <= '0;
      tile     <= '0;
      tiles_q  <= cfg_tiles;
      pixels_q <= cfg_pixels;
    end else if (hs) begin
      if (pix_end) begin
        pixel <= '0;
        tile  <= tile + TILE_WIDTH'(1);
      end else begin
        pixel <= pixel + ADDR_WIDTH'(1);
      end
    end
  end

  assign psum_rd_en   = hs;
  assign psum_rd_addr = pixel;
  assign acc_first    = hs & (tile == '0);

  acc_tag_pipe #(
    .DEPTH (ACC_LATENCY),
    .WIDTH (ADDR_WIDTH + 1)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (hs),
    .tag_in    ({tile_end, pixel}),
    .out_valid (wr_vld),
    .out_tag   (wr_tag),
    .empty     (pipe_empty)
  );

  assign psum_wr_en   = wr_vld;
  assign psum_wr_addr = wr_tag[ADDR_WIDTH-1:0];
  assign result_valid = wr_vld & wr_tag[ADDR_WIDTH];

endmodule

// File: tb/tb_channel_acc_ctrl.sv
// Scoreboard bench for channel_acc_ctrl: randomized
// beats against a per-tile/per-pixel reference walk.
module tb_channel_acc_ctrl;

  localparam int L  = 6;
  localparam int AW = 10;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] cfg_tiles;
  logic [AW:0]   cfg_pixels;
  logic          in_valid;
  logic          in_ready;
  logic          psum_rd_en;
  logic [AW-1:0] psum_rd_addr;
  logic          acc_first;
  logic          psum_wr_en;
  logic [AW-1:0] psum_wr_addr;
  logic          result_valid;
  logic          busy;
  logic          done;

  channel_acc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_tiles    (cfg_tiles),
    .cfg_pixels   (cfg_pixels),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .psum_rd_en   (psum_rd_en),
    .psum_rd_addr (psum_rd_addr),
    .acc_first    (acc_first),
    .psum_wr_en   (psum_wr_en),
    .psum_wr_addr (psum_wr_addr),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit first;
    bit last;
  } rd_t;

  typedef struct {
    int addr;
    bit last;
    int due;
  } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  pending [1024];
  int  wr_cyc  [1024];
  int  last_wr = -100;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Write-side monitor: retire expected writes in order
  always @(negedge clk) begin
    if (!rst) begin
      if (wq.size() > 0 && wq[0].due <= cyc) begin
        chk("wr_en", int'(psum_wr_en), 1);
        chk("wr_cycle", cyc, wq[0].due);
        chk("wr_addr", int'(psum_wr_addr), wq[0].addr);
        chk("result_valid", int'(result_valid),
            int'(wq[0].last));
        pending[wq[0].addr]--;
        wr_cyc[wq[0].addr] = cyc;
        last_wr = cyc;
        void'(wq.pop_front());
      end else begin
        chk("wr_en_idle", int'(psum_wr_en), 0);
      end
    end
  end

  task automatic clear_model();
    wq.delete();
    rq.delete();
    for (int i = 0; i < 1024; i++) begin
      pending[i] = 0;
      wr_cyc[i]  = -100;
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(psum_rd_en), 0);
    chk({tag, "_rd_addr"}, int'(psum_rd_addr), 0);
    chk({tag, "_first"}, int'(acc_first), 0);
    chk({tag, "_wr_en"}, int'(psum_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(psum_wr_addr), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
  endtask

  task automatic run(int tiles, int pix, int gap,
                     bit poke, int abort);
    int  idx;
    int  budget;
    int  lastc;
    bit  er;
    bit  fire;
    int  a;
    rq.delete();
    for (int k = 0; k < tiles; k++)
      for (int p = 0; p < pix; p++)
        rq.push_back('{p, k == 0, k == tiles - 1});
    @(negedge clk); #1;
    start      = 1'b1;
    cfg_tiles  = TW'(tiles);
    cfg_pixels = (AW+1)'(pix);
    @(negedge clk); #1;
    start      = 1'b0;
    cfg_tiles  = TW'($urandom);
    cfg_pixels = (AW+1)'($urandom);
    chk("busy_after_start", int'(busy), 1);
    if (tiles == 0 || pix == 0) begin
      chk("done_zero", int'(done), 1);
      chk("ready_zero", int'(in_ready), 0);
      chk("rd_en_zero", int'(psum_rd_en), 0);
      @(negedge clk); #1;
      chk("busy_end_zero", int'(busy), 0);
      chk("done_end_zero", int'(done), 0);
      return;
    end
    idx    = 0;
    budget = 0;
    lastc  = cyc;
    while (rq.size() > 0) begin
      if (abort >= 0 && idx == abort) break;
      // A new group may only open once the previous
      // group's final write has retired, when short.
      er = (idx % pix != 0) || (pix > L) ||
           (wq.size() == 0 && last_wr < cyc);
      chk("in_ready", int'(in_ready), int'(er));
      in_valid = ($urandom_range(99) >= gap);
      start    = poke && ($urandom_range(9) == 0);
      #1;
      fire = in_valid && in_ready;
      chk("rd_en", int'(psum_rd_en), int'(fire));
      if (fire) begin
        a = rq[0].addr;
        chk("rd_addr", int'(psum_rd_addr), a);
        chk("acc_first", int'(acc_first),
            int'(rq[0].first));
        chk("raw_hazard",
            int'(pending[a] > 0 || wr_cyc[a] == cyc), 0);
        wq.push_back('{a, rq[0].last, cyc + L});
        pending[a]++;
        void'(rq.pop_front());
        idx++;
        lastc = cyc;
      end
      budget++;
      if (budget > 4000) begin
        chk("beat_timeout", rq.size(), 0);
        break;
      end
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (abort >= 0) begin
      rst = 1'b1;
      clear_model();
      @(negedge clk); #1;
      chk_all_zero("abort");
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_idle_busy", int'(busy), 0);
      return;
    end
    for (int k = 0; k < 40; k++) begin
      chk("done", int'(done), int'(cyc == lastc + L + 1));
      chk("ready_drain", int'(in_ready), 0);
      chk("busy_drain", int'(busy), 1);
      if (cyc >= lastc + L + 1) break;
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    chk("busy_end", int'(busy), 0);
    chk("done_end", int'(done), 0);
    chk("queue_empty", wq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cfg_tiles  = '0;
    cfg_pixels = '0;
    in_valid   = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    run(3, 16, 0, 1'b0, -1);
    run(2, 4, 0, 1'b0, -1);
    run(2, 8, 40, 1'b0, -1);
    run(0, 5, 0, 1'b0, -1);
    run(3, 0, 0, 1'b0, -1);
    run(3, 16, 20, 1'b1, -1);
    run(3, 6, 10, 1'b1, -1);
    run(2, 7, 0, 1'b0, -1);
    run(3, 16, 0, 1'b0, 20);
    run(2, 3, 30, 1'b0, -1);
    run(1, 1, 0, 1'b0, -1);
    for (int r = 0; r < 5; r++)
      run($urandom_range(4, 1), $urandom_range(12, 1),
          $urandom_range(50, 0), 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
